// File: rtl/grid_io_pkg.sv
// Shared types and constants for the grid I/O config array.
// FSM states and per-pad config bit layout.
package grid_io_pkg;

  localparam int CFG_BITS_PER_PAD = 2;
  localparam int DIR_OFS = 0;
  localparam int INSEL_OFS = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/grid_io_if.sv
// Per-pad control bundle between the config array and a pad cell.
// master = array side, slave = pad cell side.
interface grid_io_if;
  import grid_io_pkg::*;

  logic active;
  logic dir;
  logic insel;
  logic outpad;
  logic inpad;

  modport master (
    output active,
    output dir,
    output insel,
    output outpad,
    input  inpad
  );

  modport slave (
    input  active,
    input  dir,
    input  insel,
    input  outpad,
    output inpad
  );

endinterface

// File: rtl/grid_io_pad_cell.sv
// One I/O pad: tristate driver, input mux, optional input flop.
// Input flop present only when GRID_IO_INREG_EN is defined.
module grid_io_pad_cell
  import grid_io_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  grid_io_if.slave  cfg_if,
  inout  wire       pad_io
);

  logic oe;
  logic in_en;

  assign oe    = cfg_if.active & cfg_if.dir;
  assign in_en = cfg_if.active & ~cfg_if.dir;

  assign pad_io = oe ? cfg_if.outpad : 1'bz;

`ifdef GRID_IO_INREG_EN
  logic in_q;
  logic in_d;

  // Capture the pad only while configured; clear otherwise.
  always_comb begin
    in_d = 1'b0;
    if (cfg_if.active) in_d = pad_io;
  end

  // Input flop register.
  always_ff @(posedge clk) begin
    if (!rst_n) in_q <= 1'b0;
    else        in_q <= in_d;
  end

  // Select registered or direct pad value.
  always_comb begin
    cfg_if.inpad = 1'b0;
    if (in_en) cfg_if.inpad = cfg_if.insel ? in_q : pad_io;
  end
`else
  logic unused_insel;
  assign unused_insel = cfg_if.insel;

  // Direct pad value when configured as input.
  always_comb begin
    cfg_if.inpad = 1'b0;
    if (in_en) cfg_if.inpad = pad_io;
  end
`endif

endmodule

// File: rtl/grid_io_cfg_array.sv
// Scan-chain configured array of I/O pads with load-tracking FSM.
// Optional registered pad input: define GRID_IO_INREG_EN.
module grid_io_cfg_array #(
  parameter int NUM_PADS         = 8,
  parameter int CFG_BITS_PER_PAD = 2
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                cfg_en,
  input  logic                ccff_head,
  input  logic [NUM_PADS-1:0] outpad,
  inout  wire  [NUM_PADS-1:0] gfpga_pad_GPIO_PAD,
  output logic [NUM_PADS-1:0] inpad,
  output logic                ccff_tail,
  output logic                cfg_done
);
  import grid_io_pkg::*;

  localparam int TOTAL = CFG_BITS_PER_PAD * NUM_PADS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(TOTAL);

  logic [TOTAL-1:0] cfg_q;
  logic [TOTAL-1:0] cfg_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  state_e           state_q;
  state_e           state_d;
  logic             done_q;
  logic             done_d;

  // Chain shifts toward the tail while enabled, holds otherwise.
  always_comb begin
    cfg_d = cfg_q;
    if (cfg_en) cfg_d = {cfg_q[TOTAL-2:0], ccff_head};
  end

  // Load tracking: count shifts, abort on gap, restart on reload.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_en) begin
          state_d = SHIFT;
          count_d = CNT_ONE;
        end
      end
      SHIFT: begin
        if (cfg_en) begin
          count_d = count_q + CNT_ONE;
          if (count_q + CNT_ONE == CNT_FULL) state_d = DONE;
        end else begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      DONE: begin
        if (cfg_en) begin
          state_d = SHIFT;
          count_d = CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign done_d = (state_d == DONE);

  // State, counter, chain and done flag registers.
  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      cfg_q   <= '0;
      count_q <= '0;
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      count_q <= count_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign ccff_tail = cfg_q[TOTAL-1];
  assign cfg_done  = done_q;

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    grid_io_if pif ();

    assign pif.active = done_q;
    assign pif.dir    = cfg_q[CFG_BITS_PER_PAD*g + DIR_OFS];
    assign pif.insel  = cfg_q[CFG_BITS_PER_PAD*g + INSEL_OFS];
    assign pif.outpad = outpad[g];
    assign inpad[g]   = pif.inpad;

    grid_io_pad_cell u_cell (
      .clk    (prog_clk),
      .rst_n  (pReset),
      .cfg_if (pif),
      .pad_io (gfpga_pad_GPIO_PAD[g])
    );
  end

endmodule

// File: tb/tb_grid_io_cfg_array.sv
// Randomized bench for grid_io_cfg_array with a queue-based model.
// Model follows GRID_IO_INREG_EN when the macro is defined.
module tb_grid_io_cfg_array;

  localparam int NP = 8;
  localparam int TOT = 16;

  logic          prog_clk;
  logic          pReset;
  logic          cfg_en;
  logic          ccff_head;
  logic [NP-1:0] outpad;
  wire  [NP-1:0] pad;
  logic [NP-1:0] inpad;
  logic          ccff_tail;
  logic          cfg_done;

  logic [NP-1:0] drv_en;
  logic [NP-1:0] drv_val;

  int tests;
  int fails;

  bit     chain[$];
  int     run;
  bit     mdone;
  logic [NP-1:0] mflop;

  for (genvar k = 0; k < NP; k++) begin : g_drv
    assign pad[k] = drv_en[k] ? drv_val[k] : 1'bz;
  end

  grid_io_cfg_array #(.NUM_PADS(NP)) dut (
    .prog_clk           (prog_clk),
    .pReset             (pReset),
    .cfg_en             (cfg_en),
    .ccff_head          (ccff_head),
    .outpad             (outpad),
    .gfpga_pad_GPIO_PAD (pad),
    .inpad              (inpad),
    .ccff_tail          (ccff_tail),
    .cfg_done           (cfg_done)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  function automatic bit mdir(int k);
    return chain[2*k];
  endfunction

  function automatic bit minsel(int k);
    return chain[2*k+1];
  endfunction

  function automatic logic [NP-1:0] exp_inpad();
    logic [NP-1:0] e;
    e = '0;
    for (int k = 0; k < NP; k++) begin
      if (mdone && !mdir(k)) begin
        e[k] = drv_val[k];
`ifdef GRID_IO_INREG_EN
        if (minsel(k)) e[k] = mflop[k];
`endif
      end
    end
    return e;
  endfunction

  function automatic logic [NP-1:0] exp_pad();
    logic [NP-1:0] e;
    for (int k = 0; k < NP; k++)
      e[k] = drv_en[k] ? drv_val[k] : outpad[k];
    return e;
  endfunction

  task automatic model_edge(input logic en, input logic hd, input logic rn);
    if (!rn) begin
      for (int i = 0; i < TOT; i++) chain[i] = 1'b0;
      run = 0;
      mdone = 1'b0;
      mflop = '0;
    end else begin
      for (int k = 0; k < NP; k++)
        mflop[k] = mdone ? (drv_en[k] ? drv_val[k] : outpad[k]) : 1'b0;
      if (en) begin
        chain.push_front(hd);
        void'(chain.pop_back());
        run++;
        mdone = (run % TOT == 0);
      end else begin
        run = 0;
      end
    end
  endtask

  task automatic set_pads(input logic [NP-1:0] v);
    for (int k = 0; k < NP; k++)
      drv_en[k] = !(mdone && mdir(k));
    drv_val = v;
  endtask

  task automatic step(input logic en, input logic hd,
                      input logic rn, input logic [NP-1:0] pv);
    cfg_en = en;
    ccff_head = hd;
    pReset = rn;
    @(posedge prog_clk);
    #1;
    model_edge(en, hd, rn);
    set_pads(pv);
    #1;
  endtask

  task automatic load(input logic [TOT-1:0] c);
    for (int s = TOT - 1; s >= 0; s--)
      step(1'b1, c[s], 1'b1, NP'($urandom));
    step(1'b0, 1'b0, 1'b1, NP'($urandom));
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 8'hFF);
    step(1'b1, 1'b1, 1'b0, 8'hFF);
    tests++;
    if (cfg_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_done got %b want 0", cfg_done);
    end
    tests++;
    if (ccff_tail !== 1'b0) begin
      fails++;
      $display("FAIL reset_tail got %b want 0", ccff_tail);
    end
    tests++;
    if (inpad !== 8'h00) begin
      fails++;
      $display("FAIL reset_inpad got %h want 00", inpad);
    end
    tests++;
    if (pad !== 8'hFF) begin
      fails++;
      $display("FAIL reset_pad got %h want ff", pad);
    end
  endtask

  task automatic test_full_load();
    logic [TOT-1:0] c;
    int early;
    c = TOT'($urandom);
    c[TOT-1] = 1'b1;
    early = 0;
    for (int s = TOT - 1; s >= 0; s--) begin
      step(1'b1, c[s], 1'b1, NP'($urandom));
      if (s != 0 && cfg_done !== 1'b0) early++;
    end
    tests++;
    if (early != 0) begin
      fails++;
      $display("FAIL full_early_done got %0d want 0", early);
    end
    tests++;
    if (cfg_done !== 1'b1) begin
      fails++;
      $display("FAIL full_done got %b want 1", cfg_done);
    end
    tests++;
    if (ccff_tail !== 1'b1) begin
      fails++;
      $display("FAIL full_tail got %b want 1", ccff_tail);
    end
    tests++;
    if (inpad !== exp_inpad()) begin
      fails++;
      $display("FAIL full_inpad got %h want %h", inpad, exp_inpad());
    end
  endtask

  task automatic test_output_mode();
    logic [TOT-1:0] c;
    c = TOT'($urandom) & 16'h5555;
    c[6] = 1'b1;
    outpad = NP'($urandom);
    outpad[3] = 1'b1;
    load(c);
    for (int p = 0; p < 2; p++) begin
      set_pads(p == 0 ? 8'h00 : 8'hFF);
      #1;
      tests++;
      if (pad[3] !== 1'b1 || inpad[3] !== 1'b0) begin
        fails++;
        $display("FAIL out_pad3 got pad=%b in=%b want 1/0", pad[3], inpad[3]);
      end
      tests++;
      if (pad !== exp_pad()) begin
        fails++;
        $display("FAIL out_pads got %h want %h", pad, exp_pad());
      end
      tests++;
      if (inpad !== exp_inpad()) begin
        fails++;
        $display("FAIL out_inpad got %h want %h", inpad, exp_inpad());
      end
    end
  endtask

  task automatic test_abort();
    for (int s = 0; s < 9; s++)
      step(1'b1, 1'($urandom), 1'b1, NP'($urandom));
    step(1'b0, 1'b0, 1'b1, 8'hFF);
    tests++;
    if (cfg_done !== 1'b0) begin
      fails++;
      $display("FAIL abort_done got %b want 0", cfg_done);
    end
    tests++;
    if (inpad !== 8'h00 || pad !== 8'hFF) begin
      fails++;
      $display("FAIL abort_pads got in=%h pad=%h want 00/ff", inpad, pad);
    end
    tests++;
    if (ccff_tail !== chain[TOT-1]) begin
      fails++;
      $display("FAIL abort_tail got %b want %b", ccff_tail, chain[TOT-1]);
    end
    load(TOT'($urandom));
    tests++;
    if (cfg_done !== 1'b1) begin
      fails++;
      $display("FAIL abort_reload got %b want 1", cfg_done);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    for (int s = 0; s < 5; s++)
      step(1'b1, 1'b1, 1'b1, NP'($urandom));
    step(1'b0, 1'b0, 1'b0, 8'hFF);
    tests++;
    if (cfg_done !== 1'b0 || ccff_tail !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_state got done=%b tail=%b want 0/0",
               cfg_done, ccff_tail);
    end
    tests++;
    if (inpad !== 8'h00 || pad !== 8'hFF) begin
      fails++;
      $display("FAIL rstmid_pads got in=%h pad=%h want 00/ff", inpad, pad);
    end
    bad = 0;
    for (int s = 0; s < TOT - 1; s++) begin
      step(1'b1, 1'b1, 1'b1, NP'($urandom));
      if (ccff_tail !== 1'b0 || cfg_done !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rstmid_cleared got %0d bad shifts want 0", bad);
    end
    step(1'b1, 1'b1, 1'b1, NP'($urandom));
    tests++;
    if (cfg_done !== 1'b1 || ccff_tail !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_reload got done=%b tail=%b want 1/1",
               cfg_done, ccff_tail);
    end
  endtask

  task automatic test_inreg();
    logic [TOT-1:0] c;
    logic want;
    c = TOT'($urandom);
    c[4] = 1'b0;
    c[5] = 1'b1;
    load(c);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    tests++;
    if (inpad[2] !== 1'b0) begin
      fails++;
      $display("FAIL inreg_low got %b want 0", inpad[2]);
    end
    set_pads(8'h04);
    #1;
`ifdef GRID_IO_INREG_EN
    want = 1'b0;
`else
    want = 1'b1;
`endif
    tests++;
    if (inpad[2] !== want) begin
      fails++;
      $display("FAIL inreg_same got %b want %b", inpad[2], want);
    end
    step(1'b0, 1'b0, 1'b1, 8'h04);
    tests++;
    if (inpad[2] !== 1'b1) begin
      fails++;
      $display("FAIL inreg_next got %b want 1", inpad[2]);
    end
    tests++;
    if (inpad !== exp_inpad()) begin
      fails++;
      $display("FAIL inreg_all got %h want %h", inpad, exp_inpad());
    end
  endtask

  task automatic test_reconfig();
    int bad;
    logic [TOT-1:0] c;
    c = 16'h5555;
    outpad = 8'hFF;
    load(c);
    tests++;
    if (cfg_done !== 1'b1) begin
      fails++;
      $display("FAIL reconf_pre got %b want 1", cfg_done);
    end
    bad = 0;
    for (int s = 0; s < TOT - 1; s++) begin
      step(1'b1, 1'($urandom), 1'b1, 8'h00);
      if (cfg_done !== 1'b0 || inpad !== 8'h00 || pad !== 8'h00) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reconf_hold got %0d bad cycles want 0", bad);
    end
    step(1'b1, 1'($urandom), 1'b1, 8'h00);
    tests++;
    if (cfg_done !== 1'b1) begin
      fails++;
      $display("FAIL reconf_done got %b want 1", cfg_done);
    end
  endtask

  task automatic test_random();
    logic en;
    logic rn;
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) < 8);
      rn = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 7) == 0) outpad = NP'($urandom);
      step(en, 1'($urandom), rn, NP'($urandom));
      tests++;
      if (cfg_done !== mdone || ccff_tail !== chain[TOT-1]) begin
        fails++;
        $display("FAIL rand_ctl cyc %0d got done=%b tail=%b want %b/%b",
                 i, cfg_done, ccff_tail, mdone, chain[TOT-1]);
      end
      tests++;
      if (inpad !== exp_inpad() || pad !== exp_pad()) begin
        fails++;
        $display("FAIL rand_io cyc %0d got in=%h pad=%h want %h/%h",
                 i, inpad, pad, exp_inpad(), exp_pad());
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < TOT; i++) chain.push_back(1'b0);
    run = 0;
    mdone = 1'b0;
    mflop = '0;
    pReset = 1'b0;
    cfg_en = 1'b0;
    ccff_head = 1'b0;
    outpad = '0;
    drv_en = '1;
    drv_val = '0;
    test_reset();
    test_full_load();
    test_output_mode();
    test_abort();
    test_reset_mid();
    test_inreg();
    test_reconfig();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
